dmem_mmio_bridge: RTL
=====================

Name: dmem_mmio_bridge

Overview:
- Data-side bridge directly downstream of the pipelined MIPS core's memory stage.
- Consumes the core's M-stage bus (memwriteM, aluoutM, writedataM) and returns readdataM in the same cycle.
- Decodes each address to either the data RAM (pass-through) or a small MMIO register file: LEDs, synchronised switches, a 32-bit timer with compare match, and a level interrupt.
- Lets programs on the core do I/O and timing without any change to the core.

Parameters:
MMIO_BASE, 32'hFFFF_0000, MMIO window base; an access is MMIO when aluoutM[31:16] == MMIO_BASE[31:16].
DRAM_AW, 10, data RAM word-address width.
LED_W, 16, width of the LED output register.
SW_W, 16, width of the switch input.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
memwriteM  in  1  core store strobe (M stage)
aluoutM  in  32  core byte address (M stage)
writedataM  in  32  core store data
readdataM  out  32  load data to core, combinational, same cycle
ram_we  out  1  data RAM write enable
ram_addr  out  DRAM_AW  data RAM word address
ram_wdata  out  32  data RAM write data
ram_rdata  in  32  data RAM read data (asynchronous read)
sw_i  in  SW_W  asynchronous switch inputs
led_o  out  LED_W  LED register
irq_o  out  1  timer interrupt, level, registered

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All state clears on the rising edge of clk while rst=1; rst has priority over every write and increment in that cycle.
- Decode: is_mmio = (aluoutM[31:16] == MMIO_BASE[31:16]). The MMIO offset is aluoutM[4:2]; aluoutM[1:0] are ignored (word access only).
- RAM path:
  - ram_addr = aluoutM[DRAM_AW+1:2].
  - ram_wdata = writedataM.
  - ram_we = memwriteM & ~is_mmio.
  - Addresses above the RAM size alias into RAM; this is not an error.
- Read mux: readdataM = is_mmio ? mmio_rdata : ram_rdata. Purely combinational, zero latency.
- MMIO map (offset: register):
  - 0x00 LED: RW, LED_W bits, zero-extended on read.
  - 0x04 SW: RO, two-flop synchronised sw_i (2-cycle latency), zero-extended.
  - 0x08 COUNT: RW, 32-bit.
  - 0x0C COMPARE: RW, 32-bit.
  - 0x10 CTRL: RW. bit0 TEN (timer enable), bit1 IEN (irq enable), bit8 MATCH (sticky; write-1-to-clear). Other bits read 0.
  - 0x14: reserved; see Optional Feature.
  - 0x18, 0x1C: read 0, writes ignored.
- MMIO writes take effect at the clock edge when memwriteM=1 and is_mmio=1. A read of a register in the cycle after a write returns the new value.
- Timer:
  - When TEN=1 and there is no write to COUNT, COUNT <= COUNT+1 each tick. It wraps 32'hFFFF_FFFF -> 0 silently.
  - A write to COUNT overrides the increment in that cycle.
- Match:
  - MATCH sets on the edge after a cycle with TEN=1 and COUNT==COMPARE.
  - A W1C write to MATCH in the same cycle as a new match leaves MATCH=1 (set wins).
  - Writing 0 to bit8 leaves MATCH unchanged.
- Interrupt: irq_o <= MATCH & IEN, registered, so one cycle after the MATCH/IEN update.
- Reset values:
  - led_o=0, COUNT=0, COMPARE=32'hFFFF_FFFF, CTRL=0, irq_o=0.
  - Synchroniser flops = 0.
- No stall and no handshake: every access completes in its M-stage cycle.

Optional Feature:
Macro: DMEM_BRIDGE_PRESCALE_EN
- Defined:
  - Offset 0x14 is PRESC, RW, 8 bits, reset 0.
  - An internal 8-bit prescale counter counts each cycle while TEN=1.
  - When the prescale counter equals PRESC, it resets to 0 and issues one tick. PRESC=0 therefore gives a tick every cycle.
  - A write to PRESC clears the prescale counter.
- Undefined: a tick occurs every cycle. 0x14 reads 0 and writes are ignored. No prescale logic is synthesised.

Test Plan:
- Reset, then sw_i=16'hA5A5, load 0xFFFF0004 each cycle → readdataM=0 for the first 2 cycles, then 32'h0000A5A5; led_o=0, irq_o=0.
- Store 0x1234_5678 to 0x0000_0010, then load 0x0000_0010 → ram_we=1 with ram_addr=4 on the store; readdataM=ram_rdata=0x1234_5678; led_o unchanged.
- Store 0xFFFF_BEEF to 0xFFFF0000 → led_o=16'hBEEF next cycle, ram_we=0; load 0xFFFF0000 → 32'h0000BEEF.
- COUNT=0, COMPARE=5, CTRL=3 → MATCH set on the edge after COUNT==5; irq_o=1 one cycle later; store 0x103 to CTRL → MATCH=0, irq_o drops the following cycle.
- COUNT=32'hFFFF_FFFE, TEN=1 → reads …FFFF, then 0, then 1. A store to COUNT in the wrap cycle → the written value wins.
- With DMEM_BRIDGE_PRESCALE_EN: PRESC=3, TEN=1 → COUNT increments once every 4 cycles. Without the macro: load 0xFFFF0014 → 0.

Source files
------------

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: M-stage data bridge routing loads/stores to data RAM or MMIO (LED, switches, timer, irq); DMEM_BRIDGE_PRESCALE_EN adds a timer prescaler at 0x14
module dmem_mmio_bridge #(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int DRAM_AW = 10,
    parameter int LED_W = 16,
    parameter int SW_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic ram_we,
    output logic [DRAM_AW-1:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic [SW_W-1:0] sw_i,
    output logic [LED_W-1:0] led_o,
    output logic irq_o
);
    logic isMmio, mmioWe, tick, ten, ien, match, unusedBits;
    logic [2:0] offset;
    logic [SW_W-1:0] swMeta, swSync;
    logic [31:0] count, compare, mmioRdata;
    assign isMmio = aluoutM[31:16] == MMIO_BASE[31:16];
    assign offset = aluoutM[4:2];
    assign mmioWe = memwriteM & isMmio;
    assign ram_we = memwriteM & ~isMmio;
    assign ram_addr = aluoutM[DRAM_AW+1:2];
    assign ram_wdata = writedataM;
    assign readdataM = isMmio ? mmioRdata : ram_rdata;
    assign unusedBits = ^aluoutM;
`ifdef DMEM_BRIDGE_PRESCALE_EN
    logic [7:0] presc, presCnt;
    assign tick = ten && presCnt == presc;
    // prescaler: count while enabled, wrap on reaching PRESC, restart on any PRESC write
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            presCnt <= '0;
        end else if (mmioWe && offset == 3'd5) begin
            presc <= writedataM[7:0];
            presCnt <= '0;
        end else if (ten) begin
            presCnt <= tick ? 8'd0 : presCnt + 8'd1;
        end
    end
`else
    assign tick = ten;
`endif
    // MMIO read mux; unmapped offsets read 0
    always_comb begin
        mmioRdata = '0;
        case (offset)
            3'd0: mmioRdata = 32'(led_o);
            3'd1: mmioRdata = 32'(swSync);
            3'd2: mmioRdata = count;
            3'd3: mmioRdata = compare;
            3'd4: mmioRdata = {23'd0, match, 6'd0, ien, ten};
`ifdef DMEM_BRIDGE_PRESCALE_EN
            3'd5: mmioRdata = {24'd0, presc};
`endif
            default: mmioRdata = '0;
        endcase
    end
    // two-flop switch synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            swMeta <= '0;
            swSync <= '0;
        end else begin
            swMeta <= sw_i;
            swSync <= swMeta;
        end
    end
    // software-written registers: LED, COMPARE, CTRL enables
    always_ff @(posedge clk) begin
        if (rst) begin
            led_o <= '0;
            compare <= '1;
            ten <= 1'b0;
            ien <= 1'b0;
        end else if (mmioWe) begin
            if (offset == 3'd0) led_o <= writedataM[LED_W-1:0];
            if (offset == 3'd3) compare <= writedataM;
            if (offset == 3'd4) begin
                ten <= writedataM[0];
                ien <= writedataM[1];
            end
        end
    end
    // timer: a COUNT write beats the increment; a new match beats the W1C clear
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            match <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            count <= (mmioWe && offset == 3'd2) ? writedataM : tick ? count + 32'd1 : count;
            match <= (ten && count == compare) | (match & ~(mmioWe && offset == 3'd4 && writedataM[8]));
            irq_o <= match & ien;
        end
    end
endmodule
